// File: rtl/mul_share_pkg.sv
// Shared definitions for the time-multiplexed multiplier block.
//   DEF_*_WIDTH : default operand, product and ID widths
//   clog2       : ceiling log2 used to size requester IDs
//   stage1_t    : operand-capture record {a, b, id}
//   stage2_t    : product record {prod, id}
package mul_share_pkg;

   localparam int DEF_NUM_REQ  = 4;
   localparam int DEF_A_WIDTH  = 7;
   localparam int DEF_B_WIDTH  = 7;
   localparam int DEF_P_WIDTH  = 13;
   localparam int DEF_ID_WIDTH = 2;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   typedef struct packed {
      logic [DEF_A_WIDTH-1:0]  a;
      logic [DEF_B_WIDTH-1:0]  b;
      logic [DEF_ID_WIDTH-1:0] id;
   } stage1_t;

   typedef struct packed {
      logic [DEF_P_WIDTH-1:0]  prod;
      logic [DEF_ID_WIDTH-1:0] id;
   } stage2_t;

endpackage

// File: rtl/mul_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : per-requester request
//   ptr       : requester with highest priority this cycle
//   enable    : when low, the one-hot grant is forced to zero
//   grant     : one-hot grant (gated by enable)
//   grant_idx : index of the winning requester (ungated; 0 when no request)
module rr_arbiter
   import mul_share_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int ID_WIDTH = (clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] ptr,
   input  logic                enable,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] grant_idx
);

   logic found;

   // Scan ptr, ptr+1, ... wrapping at NUM_REQ; the first requester hit wins.
   always_comb begin
      int j;
      j         = 0;
      found     = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req[j]) begin
            found     = 1'b1;
            grant_idx = ID_WIDTH'(j);
         end
      end
   end

   always_comb begin
      grant = '0;
      if (enable && found) grant[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/mul_share_arb.sv
// One unsigned multiplier shared round-robin between NUM_REQ requesters.
// Two-stage pipeline: operand capture, then registered product.
//   ap_clk, ap_rst_n   : clock, async active-low reset
//   req_valid/ready    : per-requester handshake (at most one ready bit high)
//   req_a, req_b       : packed operands, requester i at [i*W +: W]
//   res_valid/ready    : result handshake
//   res_prod, res_id   : truncated product and issuing requester
//   busy               : either pipeline stage occupied
module mul_share_arb
   import mul_share_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int A_WIDTH  = DEF_A_WIDTH,
   parameter int B_WIDTH  = DEF_B_WIDTH,
   parameter int P_WIDTH  = DEF_P_WIDTH,
   parameter int ID_WIDTH = (clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1
) (
   input  logic                       ap_clk,
   input  logic                       ap_rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [P_WIDTH-1:0]         res_prod,
   output logic [ID_WIDTH-1:0]        res_id,
   output logic                       busy
);

   localparam int FULL_W = A_WIDTH + B_WIDTH;

   // Local records sized by this instance's parameters.
   typedef struct packed {
      logic [A_WIDTH-1:0]  a;
      logic [B_WIDTH-1:0]  b;
      logic [ID_WIDTH-1:0] id;
   } s1_rec_t;

   typedef struct packed {
      logic [P_WIDTH-1:0]  prod;
      logic [ID_WIDTH-1:0] id;
   } s2_rec_t;

   s1_rec_t             s1;
   s2_rec_t             s2;
   logic                s1_valid;
   logic                s2_valid;
   logic [ID_WIDTH-1:0] rr_ptr;
   logic                s1_free;
   logic                s2_free;
   logic                accept;
   logic                s1_move;
   logic [ID_WIDTH-1:0] grant_idx;
   logic [P_WIDTH-1:0]  s1_prod;

   assign s2_free = !s2_valid || res_ready;
   assign s1_free = !s1_valid || s2_free;
   assign s1_move = s1_valid && s2_free;
   assign accept  = |req_ready;

   // Holding reset low also blocks new accepts, so req_ready reads 0 in reset.
   rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .enable    (s1_free && ap_rst_n),
      .grant     (req_ready),
      .grant_idx (grant_idx)
   );

   // Zero-extend to the full width before multiplying, then keep the low bits.
   assign s1_prod = P_WIDTH'(FULL_W'(s1.a) * FULL_W'(s1.b));

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s1       <= '0;
         s2       <= '0;
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         rr_ptr   <= '0;
      end else begin
         if (accept) begin
            s1.a   <= req_a[grant_idx*A_WIDTH +: A_WIDTH];
            s1.b   <= req_b[grant_idx*B_WIDTH +: B_WIDTH];
            s1.id  <= grant_idx;
            rr_ptr <= (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
         end
         s1_valid <= accept || (s1_valid && !s2_free);

         if (s1_move) begin
            s2.prod <= s1_prod;
            s2.id   <= s1.id;
         end
         s2_valid <= s1_valid || (s2_valid && !res_ready);
      end
   end

   assign res_valid = s2_valid;
   assign res_prod  = s2.prod;
   assign res_id    = s2.id;
   assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_mul_share_arb.sv
module tb_mul_share_arb;

   localparam int N  = 4;
   localparam int AW = 7;
   localparam int BW = 7;
   localparam int PW = 13;
   localparam int IW = 2;

   logic            ap_clk = 1'b0;
   logic            ap_rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_a;
   logic [N*BW-1:0] req_b;
   logic            res_valid;
   logic            res_ready;
   logic [PW-1:0]   res_prod;
   logic [IW-1:0]   res_id;
   logic            busy;

   int checks   = 0;
   int failures = 0;

   mul_share_arb #(
      .NUM_REQ  (N),
      .A_WIDTH  (AW),
      .B_WIDTH  (BW),
      .P_WIDTH  (PW),
      .ID_WIDTH (IW)
   ) dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_prod  (res_prod),
      .res_id    (res_id),
      .busy      (busy)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic set_req(input int i, input int a, input int b);
      req_valid[i]         = 1'b1;
      req_a[i*AW +: AW]    = AW'(a);
      req_b[i*BW +: BW]    = BW'(b);
   endtask

   // Single operation through an otherwise idle pipeline.
   task automatic do_single(input string tag, input int idx, input int a, input int b,
                            input int exp_prod);
      set_req(idx, a, b);
      res_ready = 1'b1;
      #1;
      check({tag, "_grant"}, req_ready, 32'(1 << idx));
      tick();
      req_valid = '0;
      #1;
      check({tag, "_t1_valid"}, res_valid, 0);
      check({tag, "_t1_busy"}, busy, 1);
      tick();
      check({tag, "_t2_valid"}, res_valid, 1);
      check({tag, "_prod"}, res_prod, exp_prod);
      check({tag, "_id"}, res_id, idx);
      tick();
      check({tag, "_drained"}, res_valid, 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      ap_rst_n  = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b0;

      // Reset state
      #3;
      check("rst_res_valid", res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_prod", res_prod, 0);
      check("rst_id", res_id, 0);
      req_valid = '1;
      #1;
      check("rst_req_ready", req_ready, 0);
      req_valid = '0;
      tick();
      tick();
      ap_rst_n = 1'b1;
      tick();
      check("post_rst_valid", res_valid, 0);
      check("post_rst_busy", busy, 0);

      // Round robin, all requesters valid, a=i+1, b=3
      for (int i = 0; i < N; i++) set_req(i, i + 1, 3);
      res_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k == 8) req_valid = '0;
         #1;
         check("rr_grant", req_ready, (k < 8) ? 32'(1 << (k % 4)) : 32'd0);
         if (k >= 2) begin
            check("rr_valid", res_valid, 1);
            check("rr_id", res_id, (k - 2) % 4);
            check("rr_prod", res_prod, 3 * ((k - 2) % 4 + 1));
         end else begin
            check("rr_fill_valid", res_valid, 0);
         end
         tick();
      end
      check("rr_idle", busy, 0);

      // rr_ptr=0: single req 2 -> 9000 wraps to 808; ptr then 3
      do_single("single", 2, 100, 90, 808);
      // ptr=3, scan 3,0 -> 0; 16129 mod 8192 = 7937; ptr then 1
      do_single("edge_max", 0, 127, 127, 7937);
      // ptr=1 -> 1; ptr then 2
      do_single("edge_zero", 1, 0, 127, 0);

      // Fairness skip from ptr=2 with only 1 and 3 valid: 3,1,3,1
      set_req(1, 5, 6);
      set_req(3, 7, 8);
      res_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) req_valid = '0;
         #1;
         if (k < 4) check("fair_grant", req_ready, (k % 2 == 0) ? 32'b1000 : 32'b0010);
         else       check("fair_grant_idle", req_ready, 0);
         if (k >= 2) begin
            check("fair_valid", res_valid, 1);
            check("fair_id", res_id, ((k - 2) % 2 == 0) ? 3 : 1);
            check("fair_prod", res_prod, ((k - 2) % 2 == 0) ? 56 : 30);
         end
         tick();
      end
      check("fair_idle", busy, 0);

      // Backpressure from ptr=2: accept 2 then 3, then stall
      for (int i = 0; i < N; i++) set_req(i, i + 10, 2);
      res_ready = 1'b0;
      #1;
      check("bp_grant0", req_ready, 32'b0100);
      check("bp_valid0", res_valid, 0);
      tick();
      check("bp_grant1", req_ready, 32'b1000);
      check("bp_valid1", res_valid, 0);
      tick();
      for (int k = 2; k < 5; k++) begin
         check("bp_stall_ready", req_ready, 0);
         check("bp_stall_valid", res_valid, 1);
         check("bp_stall_id", res_id, 2);
         check("bp_stall_prod", res_prod, 24);
         tick();
      end
      req_valid = '0;
      res_ready = 1'b1;
      #1;
      check("bp_drain0_valid", res_valid, 1);
      check("bp_drain0_id", res_id, 2);
      check("bp_drain0_prod", res_prod, 24);
      tick();
      check("bp_drain1_valid", res_valid, 1);
      check("bp_drain1_id", res_id, 3);
      check("bp_drain1_prod", res_prod, 26);
      tick();
      check("bp_drained", res_valid, 0);
      check("bp_idle", busy, 0);

      // Reset with both stages full; ptr ends at 1 before reset
      set_req(0, 1, 1);
      res_ready = 1'b0;
      #1;
      check("mid_grant0", req_ready, 32'b0001);
      tick();
      check("mid_grant1", req_ready, 32'b0001);
      tick();
      check("mid_full_busy", busy, 1);
      check("mid_full_valid", res_valid, 1);
      check("mid_full_ready", req_ready, 0);
      ap_rst_n = 1'b0;
      #1;
      check("mid_rst_valid", res_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", req_ready, 0);
      tick();
      req_valid = '0;
      ap_rst_n  = 1'b1;
      tick();
      check("mid_post_valid", res_valid, 0);
      check("mid_post_busy", busy, 0);
      set_req(0, 2, 2);
      set_req(1, 3, 3);
      res_ready = 1'b1;
      #1;
      check("mid_post_ptr", req_ready, 32'b0001);
      req_valid = '0;
      tick();
      check("mid_no_stale", res_valid, 0);
      tick();
      check("mid_no_stale2", res_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
